// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants and FSM encoding for the LCD text buffer
package lcd_pkg;
  localparam int ADDR_W = 5;
  localparam logic [7:0] CHAR_BS = 8'h08;
  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_FF = 8'h0C;
  localparam logic [7:0] CHAR_MIN = 8'h20;
  localparam logic [7:0] CHAR_MAX = 8'h7E;
  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  function automatic logic is_printable(input logic [7:0] c);
    return c >= CHAR_MIN && c <= CHAR_MAX;
  endfunction
endpackage

// File: rtl/lcd_char_ram.sv
// lcd_char_ram: 32x8 character array, sync write and registered read-before-write
module lcd_char_ram
  import lcd_pkg::*;
(
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];
  always_ff @(posedge CLK) if (we) mem[waddr] <= wdata;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) rdata <= '0;
    else rdata <= mem[raddr];
endmodule

// File: rtl/lcd_text_buffer.sv
// lcd_text_buffer: 2x16 character store with cursor, control codes, clear sweep and dirty flag
module lcd_text_buffer
  import lcd_pkg::*;
#(
  parameter int COLS = 16,
  parameter int ROWS = 2,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [7:0]        IN_CHAR,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic [7:0]        RD_CHAR,
  output logic [ADDR_W-1:0] CURSOR,
  output logic              DIRTY,
  input  logic              DIRTY_CLR,
  output logic              BUSY
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(COLS * ROWS - 1);
  state_t state, state_nxt;
  logic [ADDR_W-1:0] sweep, cursor_nxt, wr_addr;
  logic [7:0] wr_data;
  logic wr_en, accept, is_print, is_bs, is_cr, is_ff, sweep_done, effect;
  assign accept = IN_VALID && IN_READY;
  assign is_print = accept && is_printable(IN_CHAR);
  assign is_bs = accept && IN_CHAR == CHAR_BS && CURSOR != '0;
  assign is_cr = accept && IN_CHAR == CHAR_CR;
  assign is_ff = accept && IN_CHAR == CHAR_FF;
  assign sweep_done = state == ST_CLEAR && sweep == LAST;
  assign effect = is_print || is_bs || is_cr || is_ff;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) state <= ST_CLEAR;
    else state <= state_nxt;
  always_comb
    state_nxt = state == ST_CLEAR ? (sweep_done ? ST_IDLE : ST_CLEAR)
                                  : (is_ff ? ST_CLEAR : ST_IDLE);
  always_comb begin
    IN_READY = state == ST_IDLE;
    BUSY = state == ST_CLEAR;
    wr_en = BUSY || is_print || is_bs;
    wr_addr = BUSY ? sweep : is_bs ? CURSOR - ADDR_W'(1) : CURSOR;
    wr_data = is_print ? IN_CHAR : BLANK;
  end
  // a form feed leaves the cursor alone until the sweep finishes
  always_comb
    cursor_nxt = sweep_done ? '0
               : is_print   ? CURSOR + ADDR_W'(1)
               : is_bs      ? CURSOR - ADDR_W'(1)
               : is_cr      ? {~CURSOR[ADDR_W-1], {(ADDR_W-1){1'b0}}}
               : CURSOR;
  always_ff @(posedge CLK or negedge RESETN)
    if (!RESETN) begin
      sweep <= '0;
      CURSOR <= '0;
      DIRTY <= 1'b0;
    end else begin
      sweep <= BUSY ? sweep + ADDR_W'(1) : '0;
      CURSOR <= cursor_nxt;
      DIRTY <= effect || sweep_done || (DIRTY && !DIRTY_CLR);
    end
  lcd_char_ram u_ram (
    .CLK(CLK),
    .RESETN(RESETN),
    .we(wr_en),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(RD_ADDR),
    .rdata(RD_CHAR)
  );
endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb_lcd_text_buffer: directed stimulus checked against a behavioural text-buffer model
module tb_lcd_text_buffer;
  logic CLK = 0, RESETN = 0, IN_VALID = 0, DIRTY_CLR = 0;
  logic [7:0] IN_CHAR = 0;
  logic [4:0] RD_ADDR = 0;
  logic IN_READY, DIRTY, BUSY;
  logic [7:0] RD_CHAR;
  logic [4:0] CURSOR;
  int n_cmp = 0, n_bad = 0;

  lcd_text_buffer dut (
    .CLK(CLK), .RESETN(RESETN), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_CHAR(IN_CHAR), .RD_ADDR(RD_ADDR), .RD_CHAR(RD_CHAR), .CURSOR(CURSOR),
    .DIRTY(DIRTY), .DIRTY_CLR(DIRTY_CLR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // model: cells, cursor, dirty, and remaining clear cycles
  logic [7:0] m_mem [32];
  bit m_ok [32];
  logic [4:0] m_cur;
  int m_left;
  bit m_dirty, m_set, m_rd_ok;
  logic [7:0] m_rd;

  always @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      m_left = 32; m_cur = 0; m_dirty = 0; m_rd = 0; m_rd_ok = 1;
    end else begin
      m_set = 0;
      m_rd = m_mem[RD_ADDR];
      m_rd_ok = m_ok[RD_ADDR];
      if (m_left > 0) begin
        m_mem[32 - m_left] = 8'h20;
        m_ok[32 - m_left] = 1;
        m_left--;
        if (m_left == 0) begin m_cur = 0; m_set = 1; end
      end else if (IN_VALID) begin
        if (IN_CHAR >= 8'h20 && IN_CHAR <= 8'h7E) begin
          m_mem[m_cur] = IN_CHAR; m_ok[m_cur] = 1; m_cur = m_cur + 5'd1; m_set = 1;
        end else if (IN_CHAR == 8'h08 && m_cur != 0) begin
          m_cur = m_cur - 5'd1; m_mem[m_cur] = 8'h20; m_ok[m_cur] = 1; m_set = 1;
        end else if (IN_CHAR == 8'h0D) begin
          m_cur = m_cur < 16 ? 5'd16 : 5'd0; m_set = 1;
        end else if (IN_CHAR == 8'h0C) begin
          m_left = 32; m_set = 1;
        end
      end
      m_dirty = m_set ? 1'b1 : DIRTY_CLR ? 1'b0 : m_dirty;
    end
  end

  always @(posedge CLK) begin
    #1;
    chk("in_ready", IN_READY, m_left == 0);
    chk("busy", BUSY, m_left != 0);
    chk("cursor", CURSOR, m_cur);
    chk("dirty", DIRTY, m_dirty);
    if (m_rd_ok) chk("rd_char", RD_CHAR, m_rd);
  end

  task automatic push(input logic [7:0] c, output int waits);
    waits = 0;
    IN_VALID = 1; IN_CHAR = c;
    while (!IN_READY && waits < 100) begin @(negedge CLK); waits++; end
    chk("push_ready", IN_READY, 1);
    @(negedge CLK);
    IN_VALID = 0;
  endtask

  task automatic put(input logic [7:0] c);
    int w;
    push(c, w);
  endtask

  task automatic rd(input logic [4:0] a, input logic [7:0] exp, input string nm);
    RD_ADDR = a;
    @(negedge CLK);
    chk(nm, RD_CHAR, exp);
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (BUSY && n < 100) begin @(negedge CLK); n++; end
  endtask

  task automatic clr_dirty;
    DIRTY_CLR = 1; @(negedge CLK); DIRTY_CLR = 0;
  endtask

  initial begin
    int n;
    logic [7:0] s;
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1);
    chk("rst_ready", IN_READY, 0);
    chk("rst_cursor", CURSOR, 0);
    chk("rst_dirty", DIRTY, 0);
    chk("rst_rd", RD_CHAR, 0);
    RESETN = 1;
    busy_len(n);
    chk("sweep_len", n, 32);
    chk("post_ready", IN_READY, 1);
    chk("post_dirty", DIRTY, 1);
    for (int i = 0; i < 32; i++) rd(5'(i), 8'h20, "blank");
    clr_dirty();
    put(8'h41); put(8'h42);
    chk("ab_cursor", CURSOR, 2);
    rd(0, 8'h41, "ab_0");
    rd(1, 8'h42, "ab_1");
    put(8'h0D); put(8'h0D);
    chk("cr_home", CURSOR, 0);
    for (int i = 0; i < 32; i++) begin
      s = i < 26 ? 8'h61 + 8'(i) : 8'h30 + 8'(i - 26);
      put(s);
    end
    chk("wrap_cursor", CURSOR, 0);
    put(8'h58);
    rd(0, 8'h58, "wrap_0");
    rd(16, 8'h71, "wrap_16");
    rd(31, 8'h35, "wrap_31");
    put(8'h78); put(8'h79);
    chk("bs_pre", CURSOR, 3);
    put(8'h08);
    chk("bs_cursor", CURSOR, 2);
    rd(2, 8'h20, "bs_cell");
    put(8'h0D);
    chk("cr_row1", CURSOR, 16);
    put(8'h0D);
    chk("cr_row0", CURSOR, 0);
    clr_dirty();
    put(8'h08);
    chk("bs0_cursor", CURSOR, 0);
    chk("bs0_dirty", DIRTY, 0);
    put(8'h01);
    chk("other_dirty", DIRTY, 0);
    put(8'h0C);
    push(8'h5A, n);
    chk("ff_stall", n, 32);
    chk("ff_cursor", CURSOR, 1);
    rd(0, 8'h5A, "ff_0");
    for (int i = 1; i < 32; i++) rd(5'(i), 8'h20, "ff_blank");
    clr_dirty();
    put(8'h0C);
    repeat (10) @(negedge CLK);
    RESETN = 0;
    repeat (2) @(negedge CLK);
    chk("mid_busy", BUSY, 1);
    chk("mid_cursor", CURSOR, 0);
    RESETN = 1;
    busy_len(n);
    chk("mid_sweep_len", n, 32);
    chk("mid_dirty", DIRTY, 1);
    DIRTY_CLR = 1;
    put(8'h51);
    DIRTY_CLR = 0;
    chk("clr_vs_set", DIRTY, 1);
    put(8'h61); put(8'h62); put(8'h63); put(8'h64);
    chk("rbw_cursor", CURSOR, 5);
    RD_ADDR = 5;
    put(8'h57);
    chk("rbw_old", RD_CHAR, 8'h20);
    rd(5, 8'h57, "rbw_new");
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
